// File: rtl/buzz_pkg.sv
// Shared types and constants for the buzzer arbiter slice: FSM state
// encodings, default field width and musical timing constants at 50 MHz.
package buzz_pkg;

    localparam int unsigned PW_DEF = 32;
    localparam int unsigned CLK_HZ = 50000000;

    // FSM state encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // Tone period in clk cycles for a note frequency in Hz
    function automatic int unsigned note_period(input int unsigned hz);
        return CLK_HZ / hz;
    endfunction

    localparam int unsigned P_M5 = CLK_HZ / 392;   // 127551
    localparam int unsigned P_A5 = CLK_HZ / 440;   // 113636
    localparam int unsigned P_C6 = CLK_HZ / 523;   // 95602

    // Quarter-note beat length (250 ms)
    localparam int unsigned BEAT_1_4 = 12500000;

endpackage

// File: rtl/buzzer_arbiter_prio_enc.sv
// Fixed-priority encoder: the lowest set bit wins. Purely combinational.
module prio_enc #(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_vec,
    output logic          valid_c,
    output logic [N-1:0]  onehot_c,
    output logic [IW-1:0] idx_c
);

    // Scan from the top so the lowest asserted index is written last
    always_comb begin
        valid_c  = 1'b0;
        onehot_c = '0;
        idx_c    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                valid_c     = 1'b1;
                onehot_c    = '0;
                onehot_c[i] = 1'b1;
                idx_c       = IW'(i);
            end
        end
    end

endmodule

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter: shares one PWM tone generator between N_REQ requesters
// by fixed priority (index 0 highest), plays each tone for its duration,
// then forces GAP_CYCLES of silence before the next arbitration.
// Optional build macro BUZZ_ARB_PREEMPT_EN lets a higher-priority request
// abort the current tone and take over with a one-cycle switch.
module buzzer_arbiter
    import buzz_pkg::*;
#(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned PW         = PW_DEF,
    parameter int unsigned GAP_CYCLES = 2500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*PW-1:0]   period_in,
    input  logic [N_REQ*PW-1:0]   dur_in,
    output logic [N_REQ-1:0]      ack,
    output logic [N_REQ-1:0]      done,
    output logic                  aborted,
    output logic                  busy,
    output logic [PW-1:0]         pwm_period,
    output logic [PW-1:0]         pwm_duty
);

    localparam int unsigned OW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : PW'(GAP_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    last_q, last_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] ack_d, done_d;
    logic             aborted_d, busy_d;
    logic [PW-1:0]    period_d, duty_d;

    logic [PW-1:0]    per_arr [N_REQ];
    logic [PW-1:0]    dur_arr [N_REQ];

    // Unpack the per-requester period/duration slices
    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_split
        assign per_arr[g] = period_in[g*PW +: PW];
        assign dur_arr[g] = dur_in[g*PW +: PW];
    end

    logic             win_valid;
    logic [N_REQ-1:0] win_onehot;
    logic [OW-1:0]    win_idx;

    // Idle-time pick among all requests
    prio_enc #(.N(N_REQ)) u_pick (
        .req_vec  (req),
        .valid_c  (win_valid),
        .onehot_c (win_onehot),
        .idx_c    (win_idx)
    );

`ifdef BUZZ_ARB_PREEMPT_EN
    logic [N_REQ-1:0] pre_mask;
    logic             pre_valid;
    logic [N_REQ-1:0] pre_onehot;
    logic [OW-1:0]    pre_idx;

    // Only requesters strictly above the current owner may preempt
    always_comb begin
        pre_mask = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            pre_mask[i] = (OW'(i) < owner_q);
        end
    end

    prio_enc #(.N(N_REQ)) u_preempt (
        .req_vec  (req & pre_mask),
        .valid_c  (pre_valid),
        .onehot_c (pre_onehot),
        .idx_c    (pre_idx)
    );
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        ack_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;
        period_d  = pwm_period;
        duty_d    = pwm_duty;

        case (state_q)
            IDLE: begin
                period_d = '0;
                duty_d   = '0;
                if (win_valid) begin
                    owner_d  = win_idx;
                    cnt_d    = '0;
                    // dur=0 is played as a single cycle
                    last_d   = (dur_arr[win_idx] == '0) ? '0 : dur_arr[win_idx] - PW'(1);
                    period_d = per_arr[win_idx];
                    duty_d   = per_arr[win_idx] >> 1;
                    ack_d    = win_onehot;
                    state_d  = PLAY;
                end
            end

            PLAY: begin
                if (cnt_q == last_q) begin
                    // Natural completion takes precedence on the final cycle
                    done_d[owner_q] = 1'b1;
                    cnt_d           = '0;
                    period_d        = '0;
                    duty_d          = '0;
                    state_d         = (GAP_CYCLES > 0) ? GAP : IDLE;
`ifdef BUZZ_ARB_PREEMPT_EN
                end else if (pre_valid) begin
                    done_d[owner_q] = 1'b1;
                    aborted_d       = 1'b1;
                    ack_d           = pre_onehot;
                    owner_d         = pre_idx;
                    cnt_d           = '0;
                    last_d          = (dur_arr[pre_idx] == '0) ? '0 : dur_arr[pre_idx] - PW'(1);
                    period_d        = per_arr[pre_idx];
                    duty_d          = per_arr[pre_idx] >> 1;
`endif
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end

            GAP: begin
                period_d = '0;
                duty_d   = '0;
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                period_d = '0;
                duty_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            owner_q    <= '0;
            ack        <= '0;
            done       <= '0;
            aborted    <= 1'b0;
            busy       <= 1'b0;
            pwm_period <= '0;
            pwm_duty   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            ack        <= ack_d;
            done       <= done_d;
            aborted    <= aborted_d;
            busy       <= busy_d;
            pwm_period <= period_d;
            pwm_duty   <= duty_d;
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench for buzzer_arbiter: stimulus pushes expected ack/done
// events, a negedge monitor pops and compares them. dut runs GAP_CYCLES=4,
// dut_ng runs GAP_CYCLES=0. Build with BUZZ_ARB_PREEMPT_EN for the
// preemption variant of the takeover scenario.
`timescale 1ns/1ps
module tb_buzzer_arbiter;

    localparam int unsigned PW = 32;
    localparam int unsigned NR = 3;

    typedef struct {
        bit             is_done;
        logic [NR-1:0]  vec;
        logic           ab;
        logic [PW-1:0]  per;
        logic [PW-1:0]  duty;
        int unsigned    n;      // done: tone length; ack: spacing from previous ack (0 = unchecked)
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst     [2];
    logic [NR-1:0]    req     [2];
    logic [NR*PW-1:0] per_in  [2];
    logic [NR*PW-1:0] dur_in  [2];
    logic [NR-1:0]    ack     [2];
    logic [NR-1:0]    done    [2];
    logic             aborted [2];
    logic             busy    [2];
    logic [PW-1:0]    pwm_p   [2];
    logic [PW-1:0]    pwm_d   [2];

    buzzer_arbiter #(.N_REQ(NR), .PW(PW), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst(rst[0]), .req(req[0]), .period_in(per_in[0]), .dur_in(dur_in[0]),
        .ack(ack[0]), .done(done[0]), .aborted(aborted[0]), .busy(busy[0]),
        .pwm_period(pwm_p[0]), .pwm_duty(pwm_d[0])
    );

    buzzer_arbiter #(.N_REQ(NR), .PW(PW), .GAP_CYCLES(0)) dut_ng (
        .clk(clk), .rst(rst[1]), .req(req[1]), .period_in(per_in[1]), .dur_in(dur_in[1]),
        .ack(ack[1]), .done(done[1]), .aborted(aborted[1]), .busy(busy[1]),
        .pwm_period(pwm_p[1]), .pwm_duty(pwm_d[1])
    );

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    ev_t         exp_q [2][$];

    int unsigned   last_ack  [2];
    int unsigned   last_done [2];
    bit            tone_on   [2];
    bit            tone_bad  [2];
    logic [PW-1:0] tone_p    [2];
    logic [PW-1:0] tone_d    [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, want);
        end
    endtask

    // Monitor: pop and compare whenever a DUT pulses done or ack
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ev_t e;
            if (rst[d]) tone_on[d] = 1'b0;
            if (done[d] != '0) begin
                if (exp_q[d].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut%0d unexpected_done: got %b, required none", d, done[d]);
                end else begin
                    e = exp_q[d].pop_front();
                    check($sformatf("dut%0d done_order", d), 64'(1), 64'(e.is_done));
                    check($sformatf("dut%0d done_vec", d), 64'(done[d]), 64'(e.vec));
                    check($sformatf("dut%0d done_aborted", d), 64'(aborted[d]), 64'(e.ab));
                    check($sformatf("dut%0d tone_len", d), 64'(cyc - last_ack[d]), 64'(e.n));
                    check($sformatf("dut%0d tone_pwm_steady", d), 64'(tone_bad[d]), 64'(0));
                    if (!e.ab) check($sformatf("dut%0d pwm_off_after_tone", d), 64'(pwm_p[d]), 64'(0));
                end
                tone_on[d]   = 1'b0;
                last_done[d] = cyc;
            end
            if (ack[d] != '0) begin
                if (exp_q[d].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut%0d unexpected_ack: got %b, required none", d, ack[d]);
                end else begin
                    e = exp_q[d].pop_front();
                    check($sformatf("dut%0d ack_order", d), 64'(0), 64'(e.is_done));
                    check($sformatf("dut%0d ack_vec", d), 64'(ack[d]), 64'(e.vec));
                    check($sformatf("dut%0d ack_period", d), 64'(pwm_p[d]), 64'(e.per));
                    check($sformatf("dut%0d ack_duty", d), 64'(pwm_d[d]), 64'(e.duty));
                    if (e.n != 0) check($sformatf("dut%0d ack_spacing", d), 64'(cyc - last_ack[d]), 64'(e.n));
                    tone_p[d] = e.per;
                    tone_d[d] = e.duty;
                end
                last_ack[d] = cyc;
                tone_on[d]  = 1'b1;
                tone_bad[d] = 1'b0;
            end else if (tone_on[d] && done[d] == '0) begin
                if (pwm_p[d] !== tone_p[d] || pwm_d[d] !== tone_d[d]) tone_bad[d] = 1'b1;
            end
        end
    end

    task automatic expect_ack(input int d, input int i, input logic [PW-1:0] p,
                              input logic [PW-1:0] du, input int unsigned sp);
        ev_t e;
        e.is_done = 1'b0; e.vec = NR'(1) << i; e.ab = 1'b0; e.per = p; e.duty = du; e.n = sp;
        exp_q[d].push_back(e);
    endtask

    task automatic expect_done(input int d, input int i, input logic ab, input int unsigned len);
        ev_t e;
        e.is_done = 1'b1; e.vec = NR'(1) << i; e.ab = ab; e.per = '0; e.duty = '0; e.n = len;
        exp_q[d].push_back(e);
    endtask

    task automatic set_req(input int d, input int i, input logic [PW-1:0] p, input logic [PW-1:0] du);
        per_in[d][i*PW +: PW] = p;
        dur_in[d][i*PW +: PW] = du;
        req[d][i] = 1'b1;
    endtask

    task automatic wait_ack(input int d, input int i);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!ack[d][i] && n < 100);
        if (!ack[d][i]) begin
            checks++; errors++;
            $display("FAIL dut%0d wait_ack%0d: got timeout, required ack within 100 cycles", d, i);
        end
        req[d][i] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int unsigned gap);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (busy[d] && n < 100);
        if (busy[d]) begin
            checks++; errors++;
            $display("FAIL dut%0d wait_idle: got timeout, required busy low within 100 cycles", d);
        end else begin
            check($sformatf("dut%0d gap_len", d), 64'(cyc - last_done[d]), 64'(gap));
        end
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("dut%0d %s_ack", d, tag), 64'(ack[d]), 64'(0));
        check($sformatf("dut%0d %s_done", d, tag), 64'(done[d]), 64'(0));
        check($sformatf("dut%0d %s_aborted", d, tag), 64'(aborted[d]), 64'(0));
        check($sformatf("dut%0d %s_busy", d, tag), 64'(busy[d]), 64'(0));
        check($sformatf("dut%0d %s_period", d, tag), 64'(pwm_p[d]), 64'(0));
        check($sformatf("dut%0d %s_duty", d, tag), 64'(pwm_d[d]), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = '0; per_in[d] = '0; dur_in[d] = '0;
            last_ack[d] = 0; last_done[d] = 0; tone_on[d] = 1'b0; tone_bad[d] = 1'b0;
            tone_p[d] = '0; tone_d[d] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        check_zero(0, "reset");
        check_zero(1, "reset");

        // Single tone from the lowest-priority requester
        expect_ack(0, 2, 100, 50, 0);
        expect_done(0, 2, 1'b0, 10);
        set_req(0, 2, 100, 10);
        wait_ack(0, 2);
        wait_idle(0, 4);

        // Simultaneous requests: 0 first, 1 after 10+4+1 cycles
        expect_ack(0, 0, 200, 100, 0);
        expect_done(0, 0, 1'b0, 10);
        expect_ack(0, 1, 300, 150, 15);
        expect_done(0, 1, 1'b0, 10);
        set_req(0, 0, 200, 10);
        set_req(0, 1, 300, 10);
        wait_ack(0, 0);
        wait_ack(0, 1);
        wait_idle(0, 4);

        // Rest tone, then zero duration
        expect_ack(0, 1, 0, 0, 0);
        expect_done(0, 1, 1'b0, 5);
        set_req(0, 1, 0, 5);
        wait_ack(0, 1);
        wait_idle(0, 4);
        expect_ack(0, 2, 60, 30, 0);
        expect_done(0, 2, 1'b0, 1);
        set_req(0, 2, 60, 0);
        wait_ack(0, 2);
        wait_idle(0, 4);

        // Reset mid-tone: outputs clear, no done pulse, next request served
        expect_ack(0, 1, 80, 40, 0);
        set_req(0, 1, 80, 10);
        wait_ack(0, 1);
        repeat (2) @(negedge clk);
        #1;
        rst[0] = 1'b1;
        @(negedge clk); #1;
        rst[0] = 1'b0;
        check_zero(0, "midtone_reset");
        repeat (12) @(negedge clk);
        #1;
        expect_ack(0, 1, 90, 45, 0);
        expect_done(0, 1, 1'b0, 3);
        set_req(0, 1, 90, 3);
        wait_ack(0, 1);
        wait_idle(0, 4);

        // Higher-priority request arriving mid-tone
        expect_ack(0, 2, 100, 50, 0);
`ifdef BUZZ_ARB_PREEMPT_EN
        expect_done(0, 2, 1'b1, 4);
        expect_ack(0, 0, 40, 20, 4);
`else
        expect_done(0, 2, 1'b0, 10);
        expect_ack(0, 0, 40, 20, 15);
`endif
        expect_done(0, 0, 1'b0, 4);
        set_req(0, 2, 100, 10);
        wait_ack(0, 2);
        repeat (3) @(negedge clk);
        #1;
        set_req(0, 0, 40, 4);
        wait_ack(0, 0);
        wait_idle(0, 4);

        // No gap: odd period, back-to-back with one idle cycle
        expect_ack(1, 0, 7, 3, 0);
        expect_done(1, 0, 1'b0, 3);
        expect_ack(1, 1, 9, 4, 4);
        expect_done(1, 1, 1'b0, 2);
        set_req(1, 0, 7, 3);
        set_req(1, 1, 9, 2);
        wait_ack(1, 0);
        wait_ack(1, 1);
        wait_idle(1, 0);

        repeat (3) @(negedge clk);
        #1;
        check("dut0 queue_drained", 64'(exp_q[0].size()), 64'(0));
        check("dut1 queue_drained", 64'(exp_q[1].size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
